// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_t : arbiter FSM state encoding
//   - baud/clock constants used to derive the frame-completion timeout
//   - small constant helpers used for parameter-derived widths
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned FRAME_BITS   = 11;  // start + 8 data + parity + stop
  localparam int unsigned BAUD_4800    = 4_800;
  localparam int unsigned BAUD_9600    = 9_600;
  localparam int unsigned BAUD_115200  = 115_200;
  localparam int unsigned BAUD_SLOWEST = BAUD_4800;

  // Clock cycles taken by one frame at the given baud rate.
  function automatic int unsigned frame_cycles(input int unsigned baud);
    return FRAME_BITS * (CLK_HZ / baud);
  endfunction

  // One slowest-baud frame is ~114.6k cycles; the default leaves some margin.
  localparam int unsigned TIMEOUT_DEFAULT = 120_000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the requester handshake and transmitter protocol signals.
//   req_valid/req_data/req_ready : NUM_REQ byte producers (byte i at [8i+7:8i])
//   tx_send/tx_data              : strobe and byte to the UART transmitter
//   tx_active_flag/tx_done_flag  : transmitter frame status
// Modports: slave = arbiter side, master = requesters + transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_active_flag;
  logic                 tx_done_flag;

  modport slave (
    input  req_valid, req_data, tx_active_flag, tx_done_flag,
    output req_ready, tx_send, tx_data
  );

  modport master (
    output req_valid, req_data, tx_active_flag, tx_done_flag,
    input  req_ready, tx_send, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. Searches i_last+1, i_last+2, ... (mod
// NUM_REQ) and returns the first set request.
//   i_valid  : request vector
//   i_last   : index granted most recently
//   o_onehot : one-hot winner (all zero when no request)
//   o_idx    : winner index
//   o_any    : at least one request present
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [NUM_REQ-1:0]         o_onehot,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  int unsigned w_cand;

  always_comb begin
    o_any    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_cand   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = (32'(i_last) + k) % NUM_REQ;
      if (!o_any && i_valid[IW'(w_cand)]) begin
        o_any = 1'b1;
        o_idx = IW'(w_cand);
      end
    end
    if (o_any) o_onehot[o_idx] = 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers. Picks a requester
// round-robin, latches its byte, drives the send/active/done protocol, keeps a
// minimum idle gap after each frame and flags frames that never complete.
//   clk, rst     : clock, synchronous active-high reset
//   arb_if       : requester handshake + transmitter protocol (slave side)
//   grant_id     : requester owning the current frame
//   busy         : arbiter is not idle
//   timeout_err  : sticky, set when a frame is abandoned; cleared by rst
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned SEND_HOLD      = 8,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.slave           arb_if,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(max3(TIMEOUT_CYCLES, GAP_CYCLES, SEND_HOLD) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SEND_HOLD - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam arb_state_t    AFTER_DONE = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t         r_state, w_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic [IW-1:0]      r_last_grant;
  logic [IW-1:0]      r_grant;
  logic [7:0]         r_tx_data;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_tmo_err;

  logic               w_accept;
  logic               w_set_err;
  logic               w_any;
  logic [NUM_REQ-1:0] w_onehot;
  logic [IW-1:0]      w_idx;
  logic [7:0]         w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = arb_if.req_data[8*g +: 8];
  end

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_valid  (arb_if.req_valid),
    .i_last   (r_last_grant),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_grant      <= '0;
      r_tx_data    <= '0;
      r_ready      <= '0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ready <= w_accept ? w_onehot : '0;
      if (w_accept) begin
        r_tx_data    <= w_bytes[w_idx];
        r_grant      <= w_idx;
        r_last_grant <= w_idx;
      end
      if (w_set_err) r_tmo_err <= 1'b1;
    end
  end

  // One counter serves all timing: it restarts at LAUNCH entry, so while in
  // LAUNCH it measures both the send hold and the frame timeout, and it
  // restarts again at GAP entry to measure the idle gap.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_set_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept   = 1'b1;
          w_next     = LAUNCH;
          w_cnt_next = '0;
        end
      end
      LAUNCH, WAIT_DONE: begin
        w_cnt_next = r_cnt + CW'(1);
        // done outranks the timeout on the same cycle
        if (arb_if.tx_done_flag) begin
          w_next     = AFTER_DONE;
          w_cnt_next = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_set_err  = 1'b1;
          w_next     = AFTER_DONE;
          w_cnt_next = '0;
        end else if (r_state == LAUNCH &&
                     (arb_if.tx_active_flag || r_cnt == HOLD_LAST)) begin
          w_next = WAIT_DONE;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  assign arb_if.req_ready = r_ready;
  assign arb_if.tx_send   = (r_state == LAUNCH);
  assign arb_if.tx_data   = r_tx_data;
  assign grant_id         = r_grant;
  assign busy             = (r_state != IDLE);
  assign timeout_err      = r_tmo_err;
endmodule
